// File: rtl/conv_code_pkg.sv
// Shared constants for the rate-1/2, K=3 convolutional code used by the
// encoder and the Viterbi decoder.
//   K, NSTATES   constraint length and trellis size
//   G0, G1       generators for sym[1] and sym[0] (bit2 = current input)
//   exp_sym()    code symbol emitted when input u is applied in state s
//   hamming2()   distance between two 2-bit symbols (branch metric)
//   dec_state_t  decoder FSM state encoding
package conv_code_pkg;

    localparam int K            = 3;
    localparam int NSTATES      = 1 << (K - 1);
    localparam logic [2:0] G0   = 3'b111;
    localparam logic [2:0] G1   = 3'b101;
    localparam int TB_DEPTH_DEF = 12;
    localparam int PM_W_DEF     = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } dec_state_t;

    // Shift register seen by the encoder is {u, s[1], s[0]}.
    function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic u);
        logic [2:0] r;
        r = {u, state};
        return {^(r & G0), ^(r & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage

// File: rtl/viterbi_decoder_if.sv
// Symbol-in / bit-out link of the Viterbi decoder.
//   in_valid, in_sym, in_last   symbol stream towards the decoder
//   in_ready                    decoder can take a symbol this cycle
//   out_valid, out_bit, out_last decoded bit strobe (no backpressure)
// master: the side feeding symbols and consuming bits; slave: the decoder.
interface viterbi_decoder_if;

    logic       in_valid;
    logic [1:0] in_sym;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;

    modport master (
        output in_valid, in_sym, in_last,
        input  in_ready, out_valid, out_bit, out_last
    );

    modport slave (
        input  in_valid, in_sym, in_last,
        output in_ready, out_valid, out_bit, out_last
    );

endinterface

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state of the register-exchange decoder.
//   pm0/pm1     path metrics of the two predecessors ({ns[0],0}, {ns[0],1})
//   bm0/bm1     branch metrics on the two incoming branches
//   surv0/surv1 survivor registers of the two predecessors
//   u           decoded bit this state implies (ns[1]), appended to the survivor
//   pm_out      winning saturated metric
//   surv_out    winning survivor shifted by one with u appended at bit 0
module viterbi_acs
    import conv_code_pkg::*;
#(
    parameter int PM_W     = PM_W_DEF,
    parameter int TB_DEPTH = TB_DEPTH_DEF
) (
    input  logic [PM_W-1:0]     pm0,
    input  logic [PM_W-1:0]     pm1,
    input  logic [1:0]          bm0,
    input  logic [1:0]          bm1,
    input  logic [TB_DEPTH-1:0] surv0,
    input  logic [TB_DEPTH-1:0] surv1,
    input  logic                u,
    output logic [PM_W-1:0]     pm_out,
    output logic [TB_DEPTH-1:0] surv_out
);

    localparam logic [PM_W-1:0] PM_MAX = '1;

    logic [PM_W:0]         sum0;
    logic [PM_W:0]         sum1;
    logic [PM_W-1:0]       cand0;
    logic [PM_W-1:0]       cand1;
    logic                  dec;
    logic [TB_DEPTH-1:0]   surv_sel;

    always_comb begin
        sum0  = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
        sum1  = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
        cand0 = sum0[PM_W] ? PM_MAX : sum0[PM_W-1:0];
        cand1 = sum1[PM_W] ? PM_MAX : sum1[PM_W-1:0];
        // Strict compare: a tie keeps the lower-index predecessor.
        dec      = (cand1 < cand0);
        pm_out   = dec ? cand1 : cand0;
        surv_sel = dec ? surv1 : surv0;
        // Oldest bit falls off the top; newest decision enters at bit 0.
        surv_out = (surv_sel << 1) | TB_DEPTH'(u);
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, rate 1/2, K=3, register-exchange survivors.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of viterbi_decoder_if (symbols in, decoded bits out)
//
// state | meaning
// IDLE  | metrics at initial values, waiting for the first symbol of a frame
// RUN   | accepting symbols, one decoded bit per accept once D symbols are in
// DRAIN | frame closed, flushing the remaining bits of survivor 0
module viterbi_decoder
    import conv_code_pkg::*;
#(
    parameter int TB_DEPTH = TB_DEPTH_DEF,
    parameter int PM_W     = PM_W_DEF
) (
    input logic              clk,
    input logic              rst_n,
    viterbi_decoder_if.slave bus
);

    localparam int               CNT_W   = $clog2(TB_DEPTH + 1);
    localparam logic [PM_W-1:0]  PM_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TB_DEPTH);

    dec_state_t          state_q;
    dec_state_t          state_d;
    logic [PM_W-1:0]     pm_q       [NSTATES];
    logic [TB_DEPTH-1:0] surv_q     [NSTATES];
    logic [PM_W-1:0]     pm_acs     [NSTATES];
    logic [TB_DEPTH-1:0] surv_acs   [NSTATES];
    logic [CNT_W-1:0]    sym_cnt_q;
    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    last_idx;
    logic [CNT_W-1:0]    drain_idx;
    logic [TB_DEPTH-1:0] drain_sr_q;
    logic [CNT_W-1:0]    drain_left_q;
    logic                out_valid_q;
    logic                out_bit_q;
    logic                out_last_q;
    logic                accept;
    logic                drain_done;
    logic [PM_W-1:0]     min01, min23, pm_min;
    logic [1:0]          best01, best23, best_new;

    assign bus.in_ready  = (state_q != DRAIN);
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_last  = out_last_q;

    assign accept     = bus.in_valid & bus.in_ready;
    assign drain_done = (state_q == DRAIN) && (drain_left_q == '0);
    assign cnt_next   = (sym_cnt_q == CNT_SAT) ? sym_cnt_q : sym_cnt_q + CNT_W'(1);
    assign last_idx   = cnt_next - CNT_W'(1);
    assign drain_idx  = drain_left_q - CNT_W'(1);

    for (genvar ns = 0; ns < NSTATES; ns++) begin : g_acs
        localparam logic [1:0] NS = 2'(ns);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};
        logic [1:0] bm0;
        logic [1:0] bm1;

        assign bm0 = hamming2(bus.in_sym, exp_sym(P0, NS[1]));
        assign bm1 = hamming2(bus.in_sym, exp_sym(P1, NS[1]));

        viterbi_acs #(
            .PM_W     (PM_W),
            .TB_DEPTH (TB_DEPTH)
        ) u_acs (
            .pm0      (pm_q[P0]),
            .pm1      (pm_q[P1]),
            .bm0      (bm0),
            .bm1      (bm1),
            .surv0    (surv_q[P0]),
            .surv1    (surv_q[P1]),
            .u        (NS[1]),
            .pm_out   (pm_acs[ns]),
            .surv_out (surv_acs[ns])
        );
    end

    // Compare tree over the new metrics: yields both the normalisation
    // offset and the best state. Ties resolve towards the lower index.
    always_comb begin
        min01    = pm_acs[0];
        best01   = 2'd0;
        min23    = pm_acs[2];
        best23   = 2'd2;
        pm_min   = '0;
        best_new = 2'd0;
        if (pm_acs[1] < pm_acs[0]) begin
            min01  = pm_acs[1];
            best01 = 2'd1;
        end
        if (pm_acs[3] < pm_acs[2]) begin
            min23  = pm_acs[3];
            best23 = 2'd3;
        end
        if (min23 < min01) begin
            pm_min   = min23;
            best_new = best23;
        end else begin
            pm_min   = min01;
            best_new = best01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = bus.in_last ? DRAIN : RUN;
            RUN:     if (accept && bus.in_last) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTATES; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_MAX;
                surv_q[i] <= '0;
            end
            sym_cnt_q    <= '0;
            drain_sr_q   <= '0;
            drain_left_q <= '0;
            out_valid_q  <= 1'b0;
            out_bit_q    <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            if (accept) begin
                for (int i = 0; i < NSTATES; i++) begin
                    pm_q[i]   <= pm_acs[i] - pm_min;
                    surv_q[i] <= surv_acs[i];
                end
                sym_cnt_q <= cnt_next;
                if (bus.in_last) begin
                    // Zero tail forces the true path into state 0, so the
                    // closing symbol already reads survivor 0. Its oldest
                    // still-unreleased bit sits at position cnt_next-1.
                    out_valid_q  <= 1'b1;
                    out_bit_q    <= surv_acs[0][last_idx];
                    out_last_q   <= (cnt_next == CNT_W'(1));
                    drain_sr_q   <= surv_acs[0];
                    drain_left_q <= last_idx;
                end else if (cnt_next == CNT_SAT) begin
                    out_valid_q <= 1'b1;
                    out_bit_q   <= surv_acs[best_new][TB_DEPTH-1];
                end
            end else if (state_q == DRAIN) begin
                if (drain_left_q != '0) begin
                    out_valid_q  <= 1'b1;
                    out_bit_q    <= drain_sr_q[drain_idx];
                    out_last_q   <= (drain_left_q == CNT_W'(1));
                    drain_left_q <= drain_idx;
                end else begin
                    // Leaving DRAIN: next frame starts from reset metrics.
                    for (int i = 0; i < NSTATES; i++) begin
                        pm_q[i]   <= (i == 0) ? '0 : PM_MAX;
                        surv_q[i] <= '0;
                    end
                    sym_cnt_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_decoder.sv
module tb_viterbi_decoder;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         total = 0;
    int         bad   = 0;
    exp_t       exp_q[$];
    logic       fb[$];
    int         err_pos[2];
    logic [1:0] err_pat[2];
    int         acc_frame     = 0;
    int         acc_total     = 0;
    int         last_cnt      = 0;
    int         ready_low     = 0;
    int         first_out_acc = -1;
    int         a0;
    int         l0;

    always #5 clk = ~clk;

    viterbi_decoder_if bus();

    viterbi_decoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input int want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            acc_frame++;
            acc_total++;
        end
    end

    // Scoreboard consumer: every out_valid pops one expected bit.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!bus.in_ready) ready_low++;
            if (bus.out_valid) begin
                if (first_out_acc < 0) first_out_acc = acc_frame;
                if (bus.out_last) last_cnt++;
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL spurious_out: observed out_valid=1 expected out_valid=0");
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_bit", bus.out_bit, e.b);
                    check("out_last", bus.out_last, e.last);
                end
            end
        end
    end

    // Encodes fb[] with an independent encoder model, injects errors, drives
    // the symbols and pushes the expected decoded bits.
    task automatic send_frame(input int gap_pct, input bit garbage);
        logic [1:0] st;
        logic [1:0] sym;
        int n;
        int g;
        n = fb.size();
        st = 2'b00;
        acc_frame = 0;
        first_out_acc = -1;
        for (int i = 0; i < n; i++) begin
            sym = {fb[i] ^ st[1] ^ st[0], fb[i] ^ st[0]};
            st  = {fb[i], st[1]};
            for (int e = 0; e < 2; e++)
                if (err_pos[e] == i) sym = sym ^ err_pat[e];
            g = 0;
            while (gap_pct != 0 && int'($urandom_range(99, 0)) < gap_pct && g < 8) begin
                bus.in_valid = 1'b0;
                bus.in_sym   = 2'($urandom_range(3, 0));
                bus.in_last  = 1'($urandom_range(1, 0));
                @(posedge clk); #1;
                g++;
            end
            bus.in_valid = 1'b1;
            bus.in_sym   = sym;
            bus.in_last  = (i == n - 1);
            exp_q.push_back('{b: fb[i], last: (i == n - 1)});
            @(posedge clk); #1;
        end
        if (garbage) begin
            g = 0;
            bus.in_valid = 1'b1;
            while (!(bus.out_valid && bus.out_last) && g < 100) begin
                bus.in_sym  = 2'($urandom_range(3, 0));
                bus.in_last = 1'($urandom_range(1, 0));
                @(posedge clk); #1;
                g++;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_frame_out(input string tag);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_ready"}, bus.in_ready, 1);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sym   = 2'b00;
        bus.in_last  = 1'b0;
        err_pos[0] = -1; err_pos[1] = -1;
        err_pat[0] = 2'b00; err_pat[1] = 2'b00;

        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_bit", bus.out_bit, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_in_ready", bus.in_ready, 1);
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean 6-symbol frame, DRAIN length
        fb = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ready_low = 0;
        l0 = last_cnt;
        send_frame(0, 1'b0);
        wait_frame_out("t1");
        check("t1_ready_low", ready_low, 6);
        check("t1_last_cnt", last_cnt - l0, 1);

        // Third symbol corrupted 01 -> 11
        err_pos[0] = 2; err_pat[0] = 2'b10;
        send_frame(0, 1'b0);
        wait_frame_out("t2");
        err_pos[0] = -1;

        // 40 zeros: first output after the 12th accept
        fb.delete();
        for (int i = 0; i < 40; i++) fb.push_back(1'b0);
        l0 = last_cnt;
        send_frame(0, 1'b0);
        wait_frame_out("t3");
        check("t3_first_out_acc", first_out_acc, 12);
        check("t3_last_cnt", last_cnt - l0, 1);

        // 64 random bits + tail, random gaps, two isolated single-bit errors
        fb.delete();
        for (int i = 0; i < 64; i++) fb.push_back(1'($urandom_range(1, 0)));
        fb.push_back(1'b0);
        fb.push_back(1'b0);
        err_pos[0] = 10; err_pat[0] = 2'b01;
        err_pos[1] = 40; err_pat[1] = 2'b10;
        a0 = acc_total;
        send_frame(30, 1'b0);
        wait_frame_out("t4");
        check("t4_accepts", acc_total - a0, 66);
        err_pos[0] = -1; err_pos[1] = -1;

        // Garbage held valid during DRAIN
        fb = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        a0 = acc_total;
        send_frame(0, 1'b1);
        wait_frame_out("t6");
        check("t6_accepts", acc_total - a0, 6);

        // Reset in the middle of DRAIN, then a fresh frame
        send_frame(0, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", bus.out_valid, 0);
        check("t5_rst_out_bit", bus.out_bit, 0);
        check("t5_rst_out_last", bus.out_last, 0);
        check("t5_rst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        l0 = last_cnt;
        send_frame(0, 1'b0);
        wait_frame_out("t5");
        check("t5_last_cnt", last_cnt - l0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
